// File: rtl/ds_scale_ctrl.sv
// ds_scale_ctrl: frame sequencer for the 4:3 drop/average downscaler.
// Accepts a raster pixel stream, tracks the x/y position and emits a registered
// per-pixel control word (phases, line-buffer address/write, output strobe).
module ds_scale_ctrl #(
  parameter int IN_W   = 256,
  parameter int IN_H   = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              ctl_valid,
  output logic [1:0]        x_phase,
  output logic [1:0]        y_phase,
  output logic [ADDR_W-1:0] lb_addr,
  output logic              lb_we,
  output logic              emit,
  output logic              ctl_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int XW = $clog2(IN_W);
  localparam int YW = $clog2(IN_H);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [XW-1:0]     x_p0;
  logic [YW-1:0]     y_p0;
  logic [ADDR_W-1:0] addr_p0;

  logic              vld_p1;
  logic [1:0]        xph_p1;
  logic [1:0]        yph_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              we_p1;
  logic              emit_p1;
  logic              last_p1;
  logic              done_p1;

  logic accept;
  logic x_last;
  logic y_last;

  // Lines with y phase 1 and 2 are buffered; x phase 1 columns are dropped.
  function automatic logic we_decode(input logic [1:0] xp, input logic [1:0] yp);
    return ((yp == 2'd1) || (yp == 2'd2)) && (xp != 2'd1);
  endfunction

  // An output pixel is produced on every kept column of every kept line.
  function automatic logic emit_decode(input logic [1:0] xp, input logic [1:0] yp);
    return (xp != 2'd1) && (yp != 2'd1);
  endfunction

  assign in_ready = (state == S_RUN) && out_ready && !abort;
  assign accept   = in_valid && in_ready;
  assign x_last   = (x_p0 == XW'(IN_W - 1));
  assign y_last   = (y_p0 == YW'(IN_H - 1));
  assign busy     = (state != S_IDLE);

  assign ctl_valid  = vld_p1;
  assign x_phase    = xph_p1;
  assign y_phase    = yph_p1;
  assign lb_addr    = addr_p1;
  assign lb_we      = we_p1;
  assign emit       = emit_p1;
  assign ctl_last   = last_p1;
  assign frame_done = done_p1;

  // Frame FSM, position counters (stage p0) and registered control word (stage p1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      x_p0    <= '0;
      y_p0    <= '0;
      addr_p0 <= '0;
      vld_p1  <= 1'b0;
      xph_p1  <= 2'd0;
      yph_p1  <= 2'd0;
      addr_p1 <= '0;
      we_p1   <= 1'b0;
      emit_p1 <= 1'b0;
      last_p1 <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      if (abort) begin
        state   <= S_IDLE;
        x_p0    <= '0;
        y_p0    <= '0;
        addr_p0 <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state   <= S_RUN;
              x_p0    <= '0;
              y_p0    <= '0;
              addr_p0 <= '0;
            end
          end
          S_RUN: begin
            if (accept) begin
              // ---- stage p1: control word for the accepted pixel ----
              vld_p1  <= 1'b1;
              xph_p1  <= x_p0[1:0];
              yph_p1  <= y_p0[1:0];
              addr_p1 <= addr_p0;
              we_p1   <= we_decode(x_p0[1:0], y_p0[1:0]);
              emit_p1 <= emit_decode(x_p0[1:0], y_p0[1:0]);
              last_p1 <= x_last && y_last;
              done_p1 <= x_last && y_last;
              // ---- stage p0: advance raster position ----
              if (x_last) begin
                x_p0    <= '0;
                addr_p0 <= '0;
                y_p0    <= y_last ? '0 : y_p0 + YW'(1);
                if (y_last) begin
                  state <= S_DONE;
                end
              end else begin
                x_p0 <= x_p0 + XW'(1);
                if (x_p0[1:0] != 2'd1) begin
                  addr_p0 <= addr_p0 + ADDR_W'(1);
                end
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ds_scale_ctrl.sv
// Bench for ds_scale_ctrl: randomized valid/ready traffic against a pixel-index
// model whose control fields are derived arithmetically from the raster position.
module tb_ds_scale_ctrl;

  localparam int IN_W   = 256;
  localparam int IN_H   = 256;
  localparam int ADDR_W = 8;
  localparam int NPIX   = IN_W * IN_H;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              in_ready;
  logic              ctl_valid;
  logic [1:0]        x_phase;
  logic [1:0]        y_phase;
  logic [ADDR_W-1:0] lb_addr;
  logic              lb_we;
  logic              emit;
  logic              ctl_last;
  logic              busy;
  logic              frame_done;

  always #5 clk = ~clk;

  ds_scale_ctrl #(.IN_W(IN_W), .IN_H(IN_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
    .ctl_valid(ctl_valid), .x_phase(x_phase), .y_phase(y_phase),
    .lb_addr(lb_addr), .lb_we(lb_we), .emit(emit), .ctl_last(ctl_last),
    .busy(busy), .frame_done(frame_done)
  );

  // Counters and model state written only by the compare process.
  int n_checks = 0;
  int n_fail = 0;
  bit m_run = 0, m_done = 0, exp_vld = 0, exp_fd = 0;
  int m_n = 0, exp_n = 0, frame_id = 0;
  bit pend_busy0 = 0, abort_prev = 0;
  int cnt_vld = 0, cnt_emit = 0, cnt_we = 0, cnt_fd = 0;
  int stall_vld = 0, arm_ack = 0;
  int c1_xp[8], c1_em[8], c1_ad[8];
  int c255_ad = -1, c255_yp = -1, c255_we = -1;
  int c256_ad = -1, c256_yp = -1, c256_we = -1, c256_xp = -1;
  int cap_xp[2], cap_yp[2], cap_ad[2];
  int exp_xp8[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_em8[8] = '{1, 0, 1, 1, 1, 0, 1, 1};
  int exp_ad8[8] = '{0, 1, 1, 2, 3, 4, 4, 5};

  // Written only by the stimulus process.
  bit stall_win = 0;
  bit final_req = 0;
  int arm_req = 0;
  int timeouts = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Compare process: checks every cycle on the falling edge, then advances the model.
  always @(negedge clk) begin
    int x, y, xp, yp;
    bit acc;
    if (rst) begin
      chk("reset_outputs", int'({in_ready, ctl_valid, x_phase, y_phase, lb_addr,
                                 lb_we, emit, ctl_last, busy, frame_done}), 0);
      m_run = 0; m_done = 0; m_n = 0; exp_vld = 0; exp_fd = 0;
      pend_busy0 = 0; abort_prev = 0;
    end else begin
      chk("ctl_valid", int'(ctl_valid), int'(exp_vld));
      chk("frame_done", int'(frame_done), int'(exp_fd));
      chk("busy", int'(busy), int'(m_run || m_done));
      chk("in_ready", int'(in_ready), int'(m_run && out_ready && !abort));
      if (exp_vld) begin
        x = exp_n % IN_W;
        y = exp_n / IN_W;
        xp = x % 4;
        yp = y % 4;
        chk("x_phase", int'(x_phase), xp);
        chk("y_phase", int'(y_phase), yp);
        chk("lb_addr", int'(lb_addr), x - (x + 2) / 4);
        chk("lb_we", int'(lb_we), int'((yp == 1 || yp == 2) && xp != 1));
        chk("emit", int'(emit), int'(xp != 1 && yp != 1));
        chk("ctl_last", int'(ctl_last), int'(exp_n == NPIX - 1));
        if (frame_id == 1) begin
          cnt_vld++;
          cnt_emit += int'(emit);
          cnt_we += int'(lb_we);
          if (exp_n < 8) begin
            c1_xp[exp_n] = int'(x_phase);
            c1_em[exp_n] = int'(emit);
            c1_ad[exp_n] = int'(lb_addr);
          end
          if (exp_n == 255) begin
            c255_ad = int'(lb_addr); c255_yp = int'(y_phase); c255_we = int'(lb_we);
          end
          if (exp_n == 256) begin
            c256_ad = int'(lb_addr); c256_yp = int'(y_phase);
            c256_we = int'(lb_we); c256_xp = int'(x_phase);
          end
        end
      end
      if (pend_busy0) begin
        chk("busy_two_after_last", int'(busy), 0);
        pend_busy0 = 0;
      end
      if (frame_done) begin
        cnt_fd++;
        chk("frame_done_with_last", int'(ctl_last && ctl_valid), 1);
        chk("busy_at_frame_done", int'(busy), 1);
        pend_busy0 = 1;
      end
      if (abort_prev) chk("idle_after_abort", int'({busy, ctl_valid, frame_done}), 0);
      abort_prev = abort;
      if (stall_win) stall_vld += int'(ctl_valid);
      if (arm_ack < arm_req && arm_ack < 2 && ctl_valid) begin
        cap_xp[arm_ack] = int'(x_phase);
        cap_yp[arm_ack] = int'(y_phase);
        cap_ad[arm_ack] = int'(lb_addr);
        arm_ack++;
      end
      acc = m_run && out_ready && !abort && in_valid;
      exp_vld = acc;
      exp_fd = acc && (m_n == NPIX - 1);
      if (acc) exp_n = m_n;
      if (abort) begin
        m_run = 0; m_done = 0; m_n = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (m_run) begin
        if (acc) begin
          if (m_n == NPIX - 1) begin
            m_run = 0; m_done = 1; m_n = 0;
          end else begin
            m_n++;
          end
        end
      end else if (start) begin
        m_run = 1; m_n = 0; frame_id++;
      end
    end
    if (final_req) begin
      chk("t1_ctl_valid_count", cnt_vld, 65536);
      chk("t1_emit_count", cnt_emit, 36864);
      chk("t1_lb_we_count", cnt_we, 24576);
      chk("frame_done_total", cnt_fd, 1);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("t2_x_phase[%0d]", i), c1_xp[i], exp_xp8[i]);
        chk($sformatf("t2_emit[%0d]", i), c1_em[i], exp_em8[i]);
        chk($sformatf("t2_lb_addr[%0d]", i), c1_ad[i], exp_ad8[i]);
      end
      chk("t3_x255_lb_addr", c255_ad, 191);
      chk("t3_x255_y_phase", c255_yp, 0);
      chk("t3_x255_lb_we", c255_we, 0);
      chk("t3_x0y1_lb_addr", c256_ad, 0);
      chk("t3_x0y1_y_phase", c256_yp, 1);
      chk("t3_x0y1_lb_we", c256_we, 1);
      chk("t3_x0y1_x_phase", c256_xp, 0);
      chk("t4_ctl_valid_in_stall", stall_vld, 0);
      chk("captures_taken", arm_ack, 2);
      chk("t4_resume_x_phase", cap_xp[0], 0);
      chk("t4_resume_y_phase", cap_yp[0], 0);
      chk("t4_resume_lb_addr", cap_ad[0], 75);
      chk("t5_restart_x_phase", cap_xp[1], 0);
      chk("t5_restart_y_phase", cap_yp[1], 0);
      chk("t5_restart_lb_addr", cap_ad[1], 0);
      chk("wait_budgets_expired", timeouts, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Random traffic until the model has seen 'target' accepts in the current frame.
  task automatic run_until(input int target, input int budget);
    int c;
    c = 0;
    while (m_n != target) begin
      if (c == budget) begin
        timeouts++;
        $display("wait budget expired before pixel %0d", target);
        return;
      end
      in_valid  = ($urandom_range(0, 15) != 0);
      out_ready = ($urandom_range(0, 15) != 0);
      cyc();
      c++;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      cap_xp[i] = -1; cap_yp[i] = -1; cap_ad[i] = -1;
    end
    for (int i = 0; i < 8; i++) begin
      c1_xp[i] = -1; c1_em[i] = -1; c1_ad[i] = -1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b1;
    cyc();
    cyc();

    // Full frame at one pixel per cycle.
    start = 1'b1; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    begin
      int c;
      c = 0;
      while (cnt_fd == 0 && c < 70000) begin
        cyc();
        c++;
      end
      if (cnt_fd == 0) begin
        timeouts++;
        $display("wait budget expired waiting for frame_done");
      end
    end
    in_valid = 1'b1;
    repeat (4) cyc();

    // Stall at x=100, then abort at y=37 x=12.
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_until(100, 2000);
    out_ready = 1'b0;
    cyc();
    stall_win = 1'b1;
    repeat (9) cyc();
    stall_win = 1'b0;
    arm_req = 1;
    run_until(37 * IN_W + 12, 20000);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) cyc();

    // Restart, start pulse mid-frame, reset at y=5.
    arm_req = 2;
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_until(5 * IN_W - 40, 3000);
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_until(5 * IN_W + 3, 1000);
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    in_valid = 1'b1;
    repeat (5) cyc();

    final_req = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL summary_not_reached: compare process did not finish");
    $fatal(1, "bench did not complete");
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
